if_prefetch_unit: RTL and testbench

//  Parametrised instruction-fetch stage for the pipelined 16-bit CPU family.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/prefetch_fifo.sv | 69 ++++++
 rtl/if_prefetch_unit.sv | 110 +++++++++++
 tb/tb_if_prefetch_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU family pipeline.
// Default widths, reset fetch address and opcode constants.
package cpu_pkg;

   localparam int INSTR_W_DEF = 16;
   localparam int ADDR_W_DEF  = 16;

   localparam logic [15:0] RESET_PC_DEF = 16'h0000;

   typedef enum logic [3:0] {
      OP_ALU  = 4'h0,
      OP_ADDI = 4'h1,
      OP_LD   = 4'h2,
      OP_ST   = 4'h3,
      OP_BEQ  = 4'h4,
      OP_BNE  = 4'h5,
      OP_JAL  = 4'h6,
      OP_JR   = 4'h7
   } opcode_e;

   // Opcodes whose resolution may drive a fetch redirect
   function automatic logic is_redirect_op(input opcode_e op);
      return op inside {OP_BEQ, OP_BNE, OP_JAL, OP_JR};
   endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Prefetch queue: DEPTH-entry circular buffer with flush.
// No bypass; a pushed word is visible at the head next cycle.
module prefetch_fifo
   import cpu_pkg::*;
#(
   parameter int WIDTH = INSTR_W_DEF + ADDR_W_DEF,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (push) begin
            mem_d[wr_q] = wdata;
            wr_d        = wr_q + AW'(1);
         end
         if (pop) begin
            rd_d = rd_q + AW'(1);
         end
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign rdata = mem_q[rd_q];
   assign count = cnt_q;
   assign empty = (cnt_q == '0);

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction fetch stage: fetch PC, 1-cycle imem issue/response,
// prefetch queue and valid/ready hand-off to decode with redirect.
module if_prefetch_unit
   import cpu_pkg::*;
#(
   parameter int                INSTR_W  = INSTR_W_DEF,
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic               Clk,
   input  logic               Rst,
   output logic               imem_en,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               id_valid,
   input  logic               id_ready,
   output logic [INSTR_W-1:0] id_instr,
   output logic [ADDR_W-1:0]  id_pc,
   output logic [ADDR_W-1:0]  id_pc_next
);

   localparam int W  = INSTR_W + ADDR_W;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int OW = CW + 1;
   localparam logic [OW-1:0] DEPTH_O = OW'(DEPTH);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] tag_q, tag_d;
   logic              infl_q, infl_d;
   logic [W-1:0]      last_q, last_d;
   logic [ADDR_W-1:0] lnext_q, lnext_d;

   logic [W-1:0]      head;
   logic [CW-1:0]     count;
   logic              empty;
   logic              pop;
   logic              push;
   logic              issue;
   logic [OW-1:0]     occ;

   always_comb begin
      pop   = id_valid & id_ready & ~redirect_valid;
      push  = infl_q & ~redirect_valid;
      occ   = {1'b0, count} + OW'(infl_q) - OW'(pop);
      issue = ~redirect_valid & (occ < DEPTH_O);
      // Outputs sit at reset values while Rst is held low
      imem_en   = Rst & (redirect_valid | issue);
      imem_addr = (Rst & redirect_valid) ? redirect_pc : pc_q;
      pc_d = pc_q;
      if (redirect_valid) begin
         pc_d = redirect_pc + ADDR_W'(1);
      end else if (issue) begin
         pc_d = pc_q + ADDR_W'(1);
      end
      infl_d = imem_en;
      tag_d  = imem_en ? imem_addr : tag_q;
   end

   prefetch_fifo #(
      .WIDTH (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (Clk),
      .rst_n (Rst),
      .flush (redirect_valid),
      .push  (push),
      .wdata ({imem_rdata, tag_q}),
      .pop   (pop),
      .rdata (head),
      .count (count),
      .empty (empty)
   );

   // Hold the last shown head so outputs stay put when empty
   always_comb begin
      last_d  = last_q;
      lnext_d = lnext_q;
      if (!empty) begin
         last_d  = head;
         lnext_d = head[ADDR_W-1:0] + ADDR_W'(1);
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         pc_q    <= RESET_PC;
         tag_q   <= '0;
         infl_q  <= 1'b0;
         last_q  <= '0;
         lnext_q <= '0;
      end else begin
         pc_q    <= pc_d;
         tag_q   <= tag_d;
         infl_q  <= infl_d;
         last_q  <= last_d;
         lnext_q <= lnext_d;
      end
   end

   always_comb begin
      id_valid   = ~empty;
      id_instr   = empty ? last_q[W-1:ADDR_W] : head[W-1:ADDR_W];
      id_pc      = empty ? last_q[ADDR_W-1:0] : head[ADDR_W-1:0];
      id_pc_next = empty ? lnext_q : head[ADDR_W-1:0] + ADDR_W'(1);
   end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Randomized bench for if_prefetch_unit against a queue-based
// cycle model of the fetch/prefetch behaviour.
module tb_if_prefetch_unit;

   localparam int          DEPTH = 4;
   localparam logic [15:0] RPC   = 16'h0000;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   logic        imem_en;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata = '0;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_pc = '0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [15:0] id_instr;
   logic [15:0] id_pc;
   logic [15:0] id_pc_next;

   int n_chk = 0;
   int n_err = 0;
   int n_issue = 0;

   int q[$];
   bit pend;
   int pend_pc;
   int mpc;
   int lpc, linstr, lnext;

   if_prefetch_unit #(
      .INSTR_W  (16),
      .ADDR_W   (16),
      .DEPTH    (DEPTH),
      .RESET_PC (RPC)
   ) dut (
      .Clk            (Clk),
      .Rst            (Rst),
      .imem_en        (imem_en),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .id_pc_next     (id_pc_next)
   );

   always #5 Clk = ~Clk;

   // Synchronous instruction memory: word content derived from address
   always @(posedge Clk) begin
      if (imem_en) imem_rdata <= imem_addr ^ 16'hC3A5;
   end

   function automatic int word_of(input int a);
      return (a ^ 'hC3A5) & 'hFFFF;
   endfunction

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      pend   = 1'b0;
      pend_pc = 0;
      mpc    = int'(RPC);
      lpc    = 0;
      linstr = 0;
      lnext  = 0;
   endtask

   // Called at posedge+1; returns at the following posedge+1
   task automatic rst_pulse();
      redirect_valid = 1'b0;
      id_ready = 1'b0;
      Rst = 1'b0;
      #1;
      check("rst_imem_en", imem_en, 0);
      check("rst_imem_addr", imem_addr, RPC);
      check("rst_id_valid", id_valid, 0);
      check("rst_id_pc", id_pc, 0);
      check("rst_id_instr", id_instr, 0);
      check("rst_id_pc_next", id_pc_next, 0);
      model_reset();
      @(posedge Clk);
      #1;
      Rst = 1'b1;
   endtask

   task automatic cycle(input bit rv, input int rpc, input bit rdy);
      bit ev, ep, een;
      int eaddr, hp;
      redirect_valid = rv;
      redirect_pc = rpc[15:0];
      id_ready = rdy;
      #4;
      ev = (q.size() > 0);
      ep = ev && rdy && !rv;
      een = rv || ((q.size() + int'(pend) - int'(ep)) < DEPTH);
      eaddr = rv ? rpc : mpc;
      hp = ev ? q[0] : lpc;
      check("imem_en", imem_en, een);
      if (een) check("imem_addr", imem_addr, eaddr);
      check("id_valid", id_valid, ev);
      check("id_pc", id_pc, hp);
      check("id_instr", id_instr, ev ? word_of(hp) : linstr);
      check("id_pc_next", id_pc_next, ev ? ((hp + 1) & 'hFFFF) : lnext);
      if (imem_en) n_issue++;
      @(posedge Clk);
      if (ev) begin
         lpc = q[0];
         linstr = word_of(q[0]);
         lnext = (q[0] + 1) & 'hFFFF;
      end
      if (rv) begin
         q.delete();
         pend = 1'b1;
         pend_pc = rpc;
         mpc = (rpc + 1) & 'hFFFF;
      end else begin
         if (ep) void'(q.pop_front());
         if (pend) q.push_back(pend_pc);
         if (een) begin
            pend = 1'b1;
            pend_pc = mpc;
            mpc = (mpc + 1) & 'hFFFF;
         end else begin
            pend = 1'b0;
         end
      end
      #1;
   endtask

   initial begin
      int tgt;
      #1;
      rst_pulse();

      // Streaming with decode always ready
      for (int i = 0; i < 20; i++) cycle(0, 0, 1);

      // Backpressure from cycle 0: queue fills with exactly DEPTH words
      rst_pulse();
      n_issue = 0;
      for (int i = 0; i < 10; i++) cycle(0, 0, 0);
      check("bp_issue_count", n_issue, DEPTH);
      for (int i = 0; i < 12; i++) cycle(0, 0, 1);

      // Redirect to 0x0040 at cycle 10 with a partly full queue
      rst_pulse();
      for (int i = 0; i < 10; i++) cycle(0, 0, i[0]);
      cycle(1, 'h40, 1);
      for (int i = 0; i < 10; i++) cycle(0, 0, 1);

      // Wrap at the top of the address space
      cycle(1, 'hFFFF, 1);
      for (int i = 0; i < 6; i++) cycle(0, 0, 1);

      // Back-to-back redirects
      cycle(1, 'h1234, 1);
      cycle(1, 'h2000, 0);
      for (int i = 0; i < 6; i++) cycle(0, 0, 1);

      // Random traffic with occasional redirects and mid-stream resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            rst_pulse();
         end else begin
            case ($urandom_range(0, 3))
               0: tgt = 'hFFFF;
               1: tgt = 'hFFFE;
               default: tgt = int'($urandom_range(0, 'hFFFF));
            endcase
            cycle($urandom_range(0, 15) == 0, tgt,
                  $urandom_range(0, 3) != 0);
         end
      end

      // Reset while a read is being issued; no stale word afterwards
      for (int i = 0; i < 3; i++) cycle(0, 0, 1);
      rst_pulse();
      for (int i = 0; i < 8; i++) cycle(0, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
